// File: rtl/fsk_pkg.sv
//------------------------------------------------------------------------------
// Module   : fsk_pkg
// Brief    : Shared types and constants for the 2FSK modulator and its benches.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fsk_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SYM  = 1'b1
  } fsk_state_e;

  localparam logic [31:0] c_FTW_MARK   = 32'h0400_0000;
  localparam logic [31:0] c_FTW_SPACE  = 32'h0200_0000;
  localparam int          c_BAUD_DIV   = 256;
  localparam logic [7:0]  c_OFFSET_BIN = 8'h80;

  // round(amp*sin(2*pi*idx/2^aw)) in two's complement, built from a Q30
  // Taylor series on the first quadrant so it evaluates at elaboration time.
  function automatic logic [31:0] sine_lut_entry(input int unsigned idx,
                                                 input int unsigned aw,
                                                 input int unsigned dw);
    longint quarter;
    longint quad;
    longint ang;
    longint amp;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint mag;
    quarter = longint'(1) <<< (aw - 2);
    quad    = (longint'(idx) >>> (aw - 2)) & 3;
    ang     = longint'(idx) & (quarter - 1);
    if (quad == 1 || quad == 3) begin
      ang = quarter - ang;
    end
    amp  = (longint'(1) <<< (dw - 1)) - 1;
    x    = (ang * 64'sd1686629713) / quarter;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    mag = (acc * amp + (longint'(1) <<< 29)) >>> 30;
    if (quad >= 2) begin
      mag = -mag;
    end
    return 32'(mag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsk_sine_lut.sv
//------------------------------------------------------------------------------
// Module   : fsk_sine_lut
// Brief    : Full-wave signed sine ROM with registered output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fsk_sine_lut
  import fsk_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [OUT_W-1:0]  data_o
);

  localparam int DEPTH = 2 ** LUT_AW;

  logic [OUT_W-1:0] rom_w [DEPTH];
  logic [OUT_W-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [31:0] c_ENTRY = sine_lut_entry(k, LUT_AW, OUT_W);
    assign rom_w[k] = c_ENTRY[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= rom_w[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/fsk_mod.sv
//------------------------------------------------------------------------------
// Module   : fsk_mod
// Brief    : Continuous-phase 2FSK modulator: bit handshake, NCO, DAC samples.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fsk_mod
  import fsk_pkg::*;
#(
  parameter int                 PHASE_W   = 32,
  parameter int                 LUT_AW    = 10,
  parameter int                 OUT_W     = 8,
  parameter logic [PHASE_W-1:0] FTW_MARK  = c_FTW_MARK,
  parameter logic [PHASE_W-1:0] FTW_SPACE = c_FTW_SPACE,
  parameter int                 BAUD_DIV  = c_BAUD_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int               CNT_W      = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [OUT_W-1:0] c_MID      = {1'b1, {(OUT_W-1){1'b0}}};

  fsk_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sym_bit_q, sym_bit_d;
  logic               underrun_q, underrun_d;
  logic [1:0]         busy_pipe_q;
  logic [OUT_W-1:0]   data_q;
  logic [OUT_W-1:0]   lut_w;
  logic               sym_last_w;
  logic               xfer_w;

  assign sym_last_w = (state_q == SYM) && (cnt_q == c_CNT_LAST);
  assign bit_ready  = !rst && ((state_q == IDLE) || sym_last_w);
  assign xfer_w     = bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      sym_bit_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      sym_bit_q  <= sym_bit_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    sym_bit_d  = sym_bit_q;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (xfer_w) begin
          sym_bit_d = bit_in;
          cnt_d     = '0;
          state_d   = SYM;
        end
      end
      SYM: begin
        // Phase keeps advancing across a boundary so the tone switch is glitch-free.
        phase_d = phase_q + (sym_bit_q ? FTW_MARK : FTW_SPACE);
        if (cnt_q == c_CNT_LAST) begin
          cnt_d = '0;
          if (xfer_w) begin
            sym_bit_d = bit_in;
          end else begin
            state_d    = IDLE;
            phase_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  fsk_sine_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (phase_q[PHASE_W-1 -: LUT_AW]),
    .data_o (lut_w)
  );

  // busy_pipe_q[0] tracks the LUT register, busy_pipe_q[1] tracks data_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_pipe_q <= 2'b00;
      data_q      <= c_MID;
    end else begin
      busy_pipe_q <= {busy_pipe_q[0], state_q == SYM};
      data_q      <= busy_pipe_q[0] ? (lut_w ^ c_MID) : c_MID;
    end
  end

  assign data_out     = data_q;
  assign sample_valid = busy_pipe_q[1];
  assign busy         = (state_q == SYM);
  assign underrun     = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_fsk_mod.sv
//------------------------------------------------------------------------------
// Module   : tb_fsk_mod
// Brief    : Self-checking bench for fsk_mod against a real-valued tone model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fsk_mod;

  localparam int          BAUD  = 256;
  localparam longint      MASK  = 64'h0000_0000_FFFF_FFFF;
  localparam real         PI    = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] data_out;
  logic       sample_valid;
  logic       busy;
  logic       underrun;

  fsk_mod dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .data_out     (data_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tone_code(input longint ph);
    longint idx;
    real    v;
    int     r;
    logic [7:0] b;
    idx = (ph & MASK) >> 22;
    v   = 127.0 * $sin(2.0 * PI * real'(idx) / 1024.0);
    r   = $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
    b   = 8'(r);
    return b ^ 8'h80;
  endfunction

  // Reference model: symbol position, active bit and accumulated phase, with
  // the two-stage sample delay kept as plain history values.
  bit         m_in_sym = 0;
  int         m_pos = 0;
  bit         m_bit = 0;
  longint     m_phase = 0;
  bit         m_s1_v = 0;
  logic [7:0] m_s1_code = 8'h80;
  logic [7:0] m_data = 8'h80;
  bit         m_sv = 0;
  bit         m_under = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_in_sym = 0; m_pos = 0; m_bit = 0; m_phase = 0;
      m_s1_v = 0; m_s1_code = 8'h80; m_data = 8'h80; m_sv = 0; m_under = 0;
    end else begin
      m_data    = m_s1_v ? m_s1_code : 8'h80;
      m_sv      = m_s1_v;
      m_s1_code = tone_code(m_phase);
      m_s1_v    = m_in_sym;
      m_under   = 0;
      if (!m_in_sym) begin
        if (bit_valid) begin
          m_in_sym = 1; m_pos = 0; m_bit = bit_in; m_phase = 0;
        end
      end else begin
        m_phase = (m_phase + (m_bit ? 64'h0400_0000 : 64'h0200_0000)) & MASK;
        if (m_pos == BAUD - 1) begin
          m_pos = 0;
          if (bit_valid) m_bit = bit_in;
          else begin m_in_sym = 0; m_phase = 0; m_under = 1; end
        end else begin
          m_pos++;
        end
      end
    end
  end

  // Compare process plus statistics gathered away from the active edge.
  bit         chk_en = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  int         under_cnt = 0;
  int         sidx = 0;
  int         maxdiff = 0;
  bit         prev_sv = 0;
  logic [7:0] prev_d = 8'h80;
  logic [7:0] samp [0:1023];
  int         xfer_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("data_out", data_out, m_data);
      check("sample_valid", sample_valid, m_sv);
      check("busy", busy, m_in_sym);
      check("underrun", underrun, m_under);
      check("bit_ready", bit_ready, !rst && (!m_in_sym || m_pos == BAUD - 1));
    end
    if (busy) busy_cnt++;
    if (underrun) under_cnt++;
    if (bit_valid && bit_ready) xfer_cyc.push_back(cyc);
    if (sample_valid) begin
      if (!prev_sv) sidx = 0;
      else begin
        int d;
        d = int'(data_out) - int'(prev_d);
        if (d < 0) d = -d;
        if (d > maxdiff) maxdiff = d;
      end
      if (sidx < 1024) samp[sidx] = data_out;
      sidx++;
    end
    prev_sv = sample_valid;
    prev_d  = data_out;
  end

  task automatic clear_stats();
    busy_cnt = 0; under_cnt = 0; maxdiff = 0; xfer_cyc.delete();
  endtask

  // Enters and leaves just after a rising edge.
  task automatic wait_xfer(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bit_ready) break;
    end
    if (k == 2000) check({name, "_xfer_timeout"}, 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input string name);
    bit_in = b; bit_valid = 1'b1;
    wait_xfer(name);
    bit_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy && !sample_valid) break;
    end
    if (k == 3000) check({name, "_idle_timeout"}, 1, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data", data_out, 8'h80);
    check("rst_sv", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bit_ready, 1);
    @(posedge clk); #1;

    clear_stats();
    send_bit(1'b1, "mark");
    wait_idle("mark");
    check("mark_busy_len", busy_cnt, 256);
    check("mark_underrun", under_cnt, 1);
    check("mark_nsamp", sidx, 256);
    check("mark_s0", samp[0], 8'h80);
    check("mark_s16", samp[16], 8'hFF);
    check("mark_s32", samp[32], 8'h80);
    check("mark_s48", samp[48], 8'h01);
    check("mark_idle_data", data_out, 8'h80);

    clear_stats();
    send_bit(1'b0, "space");
    wait_idle("space");
    check("space_busy_len", busy_cnt, 256);
    check("space_s0", samp[0], 8'h80);
    check("space_s32", samp[32], 8'hFF);
    check("space_s64", samp[64], 8'h80);
    check("space_s96", samp[96], 8'h01);

    clear_stats();
    bit_in = 1'b1; bit_valid = 1'b1;
    wait_xfer("b2b0");
    bit_in = 1'b0;
    wait_xfer("b2b1");
    bit_in = 1'b1;
    wait_xfer("b2b2");
    bit_valid = 1'b0;
    check("b2b_no_underrun", under_cnt, 0);
    wait_idle("b2b");
    check("b2b_busy_len", busy_cnt, 768);
    check("b2b_underrun_end", under_cnt, 1);
    check("b2b_nxfer", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      check("b2b_gap1", xfer_cyc[1] - xfer_cyc[0], 256);
      check("b2b_gap2", xfer_cyc[2] - xfer_cyc[1], 256);
    end
    check("b2b_continuous", (maxdiff <= 13) ? 1 : 0, 1);

    clear_stats();
    send_bit(1'b1, "late0");
    wait_idle("late0");
    repeat (8) @(posedge clk);
    #1;
    send_bit(1'b1, "late1");
    wait_idle("late1");
    check("late_underruns", under_cnt, 2);
    check("late_s0", samp[0], 8'h80);
    check("late_s16", samp[16], 8'hFF);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 300)) @(posedge clk);
      #1;
      send_bit(1'($urandom_range(0, 1)), "rand");
    end
    wait_idle("rand");

    send_bit(1'b1, "rstmid");
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy_pre", busy, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_data", data_out, 8'h80);
    check("rstmid_sv", sample_valid, 0);
    repeat (4) begin
      @(negedge clk);
      check("rstmid_hold", data_out, 8'h80);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fsk_mod.md
Name: fsk_mod

Overview:
- 2FSK modulator: the transmit-side counterpart of the FSK demodulator chain.
- Takes a serial bit stream through a valid/ready handshake and synthesizes a continuous-phase FSK carrier with an NCO (phase accumulator plus sine LUT).
- Output is 8-bit offset-binary samples for the DAC; the same samples feed the demodulator in loopback tests.
- Mark (bit 1) and space (bit 0) tones are selected by frequency tuning word; symbol duration is a fixed clock count.

Parameters:
- PHASE_W, 32, phase accumulator width.
- LUT_AW, 10, sine LUT address width (phase_acc top LUT_AW bits).
- OUT_W, 8, output sample width.
- FTW_MARK, 32'h0400_0000, tuning word for bit 1 (fclk/64).
- FTW_SPACE, 32'h0200_0000, tuning word for bit 0 (fclk/128).
- BAUD_DIV, 256, clock cycles per symbol (must be at least 2).

Ports:
- clk, input, 1, system clock; single clock domain.
- rst, input, 1, synchronous active-high reset.
- bit_in, input, 1, symbol to transmit (1 = mark, 0 = space).
- bit_valid, input, 1, bit_in is valid.
- bit_ready, output, 1, module accepts bit_in this cycle.
- data_out, output, OUT_W, offset-binary carrier sample; 8'h80 is midscale.
- sample_valid, output, 1, data_out is a modulated sample (not idle midscale).
- busy, output, 1, state is SYM.
- underrun, output, 1, one-cycle pulse when a symbol ends with no next bit available.

Behaviour:
- Reset:
  - All registers clear synchronously on rst = 1.
  - state = IDLE, phase_acc = 0, baud_cnt = 0, sym_bit = 0.
  - data_out = 8'h80, sample_valid = 0, busy = 0, underrun = 0, bit_ready = 0 during reset.
  - Reset mid-symbol aborts immediately; no partial-symbol completion.
- Handshake:
  - A transfer occurs when bit_valid && bit_ready.
  - bit_ready = 1 when (state == IDLE) or (state == SYM && baud_cnt == BAUD_DIV-1).
  - bit_ready is combinational from state and baud_cnt only, never from bit_valid.
  - bit_in is sampled only on a transfer.
- IDLE state:
  - phase_acc held at 0; pipeline drives midscale.
  - On transfer: sym_bit <= bit_in, baud_cnt <= 0, phase_acc <= 0, state <= SYM.
- SYM state, each cycle:
  - phase_acc += (sym_bit ? FTW_MARK : FTW_SPACE), modulo 2^PHASE_W wrap.
  - baud_cnt increments.
- Symbol end (baud_cnt == BAUD_DIV-1):
  - With a transfer: sym_bit <= bit_in, baud_cnt <= 0, stay in SYM. phase_acc is NOT reset (continuous phase); the tone changes with no gap.
  - Without a transfer: underrun pulses for 1 cycle, state <= IDLE, phase_acc <= 0.
- Symbol length: each accepted bit occupies exactly BAUD_DIV SYM cycles.
- Sample pipeline (sub-module fsk_sine_lut):
  - Stage 1: registered LUT read, LUT[k] = round(127*sin(2*pi*k/1024)), signed 8-bit.
  - Stage 2: data_out <= lut_q ^ 8'h80 (signed to offset-binary conversion).
  - Latency: data_out reflects phase_acc 2 cycles earlier.
  - sample_valid is busy delayed by 2 cycles, aligned with data_out.
  - During the 2 cycles after leaving SYM, the trailing samples remain valid; then data_out returns to 8'h80.
  - In IDLE, stage 2 forces 8'h80.
- Output range: 8'h01 to 8'hFF; 8'h00 never occurs.
- Counter width: $clog2(BAUD_DIV) bits.

Decomposition:
- Shared package fsk_pkg:
  - state enum {IDLE, SYM}.
  - Default FTW_MARK, FTW_SPACE, BAUD_DIV constants, shared with the demodulator bench.
  - Offset constant 8'h80.
- Sub-module fsk_sine_lut: 1024x8 ROM, registered output, initialised from a generated constant table.
- Top level fsk_mod holds the FSM, baud counter, phase accumulator, and output register.

Test Plan:
- Reset: hold rst high 5 cycles, then release with bit_valid = 0 -> data_out = 8'h80, sample_valid = 0, busy = 0, bit_ready = 1.
- Single mark bit: bit_in = 1, bit_valid for 1 cycle ->
  - busy high exactly 256 cycles.
  - Sample 0 = 8'h80; sample 16 = 8'hFF; sample 32 = 8'h80; sample 48 = 8'h01.
  - 4 full periods, then underrun pulses once and data_out returns to 8'h80.
- Space bit: same stimulus with bit_in = 0 -> period 128 cycles, 2 periods per symbol, sample 32 = 8'hFF.
- Back-to-back "1,0,1" with bit_valid held high:
  - bit_ready pulses every 256 cycles.
  - No underrun.
  - phase_acc is continuous at each boundary: the sample after the boundary differs from the previous one by at most one tone step.
  - Total busy = 768 cycles.
- Late bit: bit_valid asserted 10 cycles after a symbol ends -> underrun pulse at the boundary, 2 trailing samples, then 8'h80; the new symbol restarts with phase 0.
- Reset mid-symbol: rst at baud_cnt = 100 of a mark symbol -> next cycle state = IDLE, phase_acc = 0, and data_out = 8'h80 from that cycle on.
